// File: rtl/lfsr_scr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_scr_pkg
// Definitions shared by the 84-bit primary LFSR scrambler and its descrambler:
//   - LFSR geometry and framing constants (marker, seed length, frame length)
//   - state encoding of the framing FSM
//   - register map (0x0a9..0x0ab scrambler side, 0x0ac..0x0af descrambler side)
//   - lfsr_step1 / lfsr_step14: one step and one full word advance of the LFSR
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_scr_pkg;

  localparam int POLY_WIDTH   = 84;
  localparam int NUM_OF_STEPS = 14;
  localparam int SEED_WORDS   = 6;
  localparam int FRAME_WORDS  = 256;

  // Wide enough to hold FRAME_WORDS itself, not just FRAME_WORDS-1.
  localparam int CNT_WIDTH = $clog2(FRAME_WORDS + 1);

  localparam logic [NUM_OF_STEPS-1:0] SYNC_WORD = 14'h3A5C;

  localparam logic [CNT_WIDTH-1:0] SEED_LAST  = CNT_WIDTH'(SEED_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } lfsr_state_e;

  // Transmit-side scrambler seed registers.
  localparam logic [11:0] ADDR_SCR_SEED_LO  = 12'h0a9;
  localparam logic [11:0] ADDR_SCR_SEED_MID = 12'h0aa;
  localparam logic [11:0] ADDR_SCR_SEED_HI  = 12'h0ab;
  // Receive-side descrambler seed and manual start.
  localparam logic [11:0] ADDR_DSC_SEED_LO  = 12'h0ac;
  localparam logic [11:0] ADDR_DSC_SEED_MID = 12'h0ad;
  localparam logic [11:0] ADDR_DSC_SEED_HI  = 12'h0ae;
  localparam logic [11:0] ADDR_DSC_START    = 12'h0af;

  // One LFSR step: shift toward the MSB, bit 83 feeds back into bit 0 and is
  // XORed into the bits just above taps 14, 29, 48, 61 and 81.
  function automatic logic [POLY_WIDTH-1:0] lfsr_step1(input logic [POLY_WIDTH-1:0] s);
    return {s[82], s[83] ^ s[81], s[80:62], s[83] ^ s[61], s[60:49],
            s[83] ^ s[48], s[47:30], s[83] ^ s[29], s[28:15],
            s[83] ^ s[14], s[13:0], s[83]};
  endfunction

  // One word advance: NUM_OF_STEPS chained steps, unrolled into a single cycle.
  function automatic logic [POLY_WIDTH-1:0] lfsr_step14(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] v;
    // NOTE: blocking assignments are correct here: each unrolled step must
    // see the result of the previous one within the same evaluation.
    v = s;
    for (int i = 0; i < NUM_OF_STEPS; i++) begin
      v = lfsr_step1(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/lfsr_descrambler_6_out_stage.sv
// -----------------------------------------------------------------------------
// lfsr_out_stage
// Single-entry valid/ready output register for descrambled words.
//   clk      in   clock
//   rst      in   synchronous active-low reset
//   i_load   in   load i_data this cycle (caller guarantees the slot is free
//                 or being drained in the same cycle)
//   i_data   in   word to load
//   i_ready  in   downstream accept
//   o_valid  out  word pending
//   o_data   out  pending word; held stable while o_valid & !i_ready
// -----------------------------------------------------------------------------
module lfsr_out_stage
  import lfsr_scr_pkg::*;
#(
  parameter int WIDTH = NUM_OF_STEPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      // A load wins over a drain: accept-and-drain keeps valid high.
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lfsr_descrambler_6.sv
// -----------------------------------------------------------------------------
// lfsr_descrambler_6
// Receive side of the 84-bit primary LFSR scrambler. Hunts for the frame
// marker, loads the six seed words that follow it, then XORs the locally
// regenerated keystream off each of the 256 payload words. After a frame the
// next word must be the marker again (reseed) or sync is declared lost.
// The seed can also be loaded and the run started over the register bus.
//   clk        in   clock
//   rst        in   synchronous active-low reset
//   write      in   register write strobe
//   addr       in   register address (0x0ac..0x0af decoded)
//   lfsrdin    in   register write data
//   in_valid   in   scrambled word valid
//   in_ready   out  word accepted when in_valid & in_ready
//   in_data    in   received 14-bit word
//   out_valid  out  descrambled word valid
//   out_ready  in   downstream accept
//   out_data   out  descrambled word
//   locked     out  high in RUN and CHECK
//   sync_lost  out  one-cycle pulse when the post-frame marker is missing
//   dout       out  current LFSR state
// -----------------------------------------------------------------------------
module lfsr_descrambler_6
  import lfsr_scr_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [11:0]             addr,
  input  logic [31:0]             lfsrdin,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_OF_STEPS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_OF_STEPS-1:0] out_data,
  output logic                    locked,
  output logic                    sync_lost,
  output logic [POLY_WIDTH-1:0]   dout
);

  lfsr_state_e             r_state;
  logic [POLY_WIDTH-1:0]   r_lfsr;
  logic [CNT_WIDTH-1:0]    r_word_cnt;
  logic                    r_sync_lost;

  logic                    w_in_ready;
  logic                    w_reg_hit;
  logic                    w_accept;
  logic                    w_load;
  logic [NUM_OF_STEPS-1:0] w_plain;
  logic [POLY_WIDTH-1:0]   w_lfsr_adv;

  // NOTE: every signal driven here gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    w_in_ready = 1'b1;
    if (r_state == RUN) begin
      // Only RUN produces output, so only RUN needs room in the out stage.
      w_in_ready = !out_valid || out_ready;
    end

    // Bus writes are honoured only in IDLE; a decoded write there takes
    // priority and the data word offered in the same cycle is dropped.
    w_reg_hit = write && (r_state == IDLE) &&
                (addr >= ADDR_DSC_SEED_LO) && (addr <= ADDR_DSC_START);

    w_accept   = in_valid && w_in_ready && !w_reg_hit;
    w_load     = w_accept && (r_state == RUN);
    w_plain    = in_data ^ r_lfsr[POLY_WIDTH-1 -: NUM_OF_STEPS];
    w_lfsr_adv = lfsr_step14(r_lfsr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_lfsr      <= '0;
      r_word_cnt  <= '0;
      r_sync_lost <= 1'b0;
    end else begin
      r_sync_lost <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_reg_hit) begin
            case (addr)
              ADDR_DSC_SEED_LO:  r_lfsr[31:0]  <= lfsrdin;
              ADDR_DSC_SEED_MID: r_lfsr[63:32] <= lfsrdin;
              ADDR_DSC_SEED_HI:  r_lfsr[83:64] <= lfsrdin[19:0];
              ADDR_DSC_START: begin
                if (lfsrdin[0]) begin
                  r_state    <= RUN;
                  r_word_cnt <= '0;
                end
              end
              default: ;
            endcase
          end else if (w_accept && (in_data == SYNC_WORD)) begin
            r_state    <= SEED;
            r_word_cnt <= '0;
          end
        end

        SEED: begin
          if (w_accept) begin
            // Shifting in from the bottom leaves the first seed word on top.
            r_lfsr <= {r_lfsr[POLY_WIDTH-NUM_OF_STEPS-1:0], in_data};
            if (r_word_cnt == SEED_LAST) begin
              r_state    <= RUN;
              r_word_cnt <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
          end
        end

        RUN: begin
          if (w_accept) begin
            r_lfsr <= w_lfsr_adv;
            if (r_word_cnt == FRAME_LAST) begin
              r_state    <= CHECK;
              r_word_cnt <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
          end
        end

        CHECK: begin
          if (w_accept) begin
            r_word_cnt <= '0;
            if (in_data == SYNC_WORD) begin
              r_state <= SEED;
            end else begin
              // LFSR is deliberately left as-is for diagnosis over dout.
              r_state     <= IDLE;
              r_sync_lost <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  lfsr_out_stage #(
    .WIDTH (NUM_OF_STEPS)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_plain),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data)
  );

  assign in_ready  = w_in_ready;
  assign locked    = (r_state == RUN) || (r_state == CHECK);
  assign sync_lost = r_sync_lost;
  assign dout      = r_lfsr;

endmodule

// File: tb/tb_lfsr_descrambler_6.sv
module tb_lfsr_descrambler_6;

  localparam logic [13:0] MARK  = 14'h3A5C;
  localparam int          FRAME = 256;
  // Galois form of the step: shift left, and when the old MSB was set XOR in
  // a 1 at bit 0 and just above each tap (14,29,48,61,81).
  localparam logic [83:0] TAPS  = (84'd1 << 82) | (84'd1 << 62) | (84'd1 << 49) |
                                  (84'd1 << 30) | (84'd1 << 15) | 84'd1;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        write     = 1'b0;
  logic [11:0] addr      = '0;
  logic [31:0] lfsrdin   = '0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [13:0] in_data   = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_data;
  logic        locked;
  logic        sync_lost;
  logic [83:0] dout;

  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [83:0] m_held    = '0;

  lfsr_descrambler_6 dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .addr      (addr),
    .lfsrdin   (lfsrdin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .locked    (locked),
    .sync_lost (sync_lost),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [83:0] m_adv(input logic [83:0] s);
    for (int i = 0; i < 14; i++) s = s[83] ? ((s << 1) ^ TAPS) : (s << 1);
    return s;
  endfunction

  function automatic logic [13:0] m_ks(input logic [83:0] s);
    return 14'(s >> 70);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; write = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [13:0] d);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [11:0] a, input logic [31:0] d);
    write = 1'b1; addr = a; lfsrdin = d;
    tick();
    write = 1'b0;
  endtask

  // Marker + seed + one full frame with random bubbles and backpressure,
  // checked against the plaintext queue. Leaves the DUT in CHECK.
  task automatic run_frame(input logic [83:0] seed, input bit bp, output logic [83:0] ks_out);
    logic [83:0] ks;
    logic [13:0] plain, prev_data;
    logic [13:0] exp_q[$];
    int          sent, got, cyc;
    bit          prev_stall, fired;
    ks = seed; sent = 0; got = 0; cyc = 0; prev_stall = 0; plain = '0; prev_data = '0;
    out_ready = 1'b1;
    send_word(MARK);
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL frame_seed_unlocked got=%b exp=0", locked); end
    for (int k = 0; k < 6; k++) send_word(14'(seed >> (70 - 14 * k)));
    n_checks++; if (locked !== 1'b1 || dout !== seed) begin n_errors++; $display("FAIL frame_seeded locked=%b dout=%h exp locked=1 dout=%h", locked, dout, seed); end
    while ((sent < FRAME || got < FRAME) && cyc < 4000) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!in_valid && sent < FRAME && $urandom_range(0, 4) != 0) begin
        plain    = 14'($urandom());
        in_data  = plain ^ m_ks(ks);
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (prev_stall) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_errors++; $display("FAIL frame_hold valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, prev_data); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL frame_extra_output data=%h expected no output", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin n_errors++; $display("FAIL frame_data word %0d got=%h exp=%h", got, out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      fired      = in_valid && in_ready;
      if (fired) begin
        exp_q.push_back(plain);
        ks = m_adv(ks);
        sent++;
      end
      @(posedge clk);
      #1;
      if (fired) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 4000) begin
      n_checks++; n_errors++;
      $display("FAIL frame_timeout sent=%0d got=%0d exp %0d each", sent, got, FRAME);
    end
    n_checks++; if (locked !== 1'b1 || in_ready !== 1'b1 || dout !== ks) begin n_errors++; $display("FAIL frame_end locked=%b in_ready=%b dout=%h exp 1 1 %h", locked, in_ready, dout, ks); end
    ks_out = ks;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (dout !== 84'h0) begin n_errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    n_checks++; if (sync_lost !== 1'b0 || out_data !== 14'h0) begin n_errors++; $display("FAIL reset_misc sync_lost=%b out_data=%h exp 0 0", sync_lost, out_data); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_seed_one();
    do_reset();
    send_word(MARK);
    for (int k = 0; k < 5; k++) send_word(14'h0000);
    send_word(14'h0001);
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL seed1_locked got=%b exp=1", locked); end
    n_checks++; if (dout !== 84'h1) begin n_errors++; $display("FAIL seed1_dout got=%h exp=%h", dout, 84'h1); end
    send_word(14'h0000);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 14'h0000) begin n_errors++; $display("FAIL seed1_out valid=%b data=%h exp 1 0000", out_valid, out_data); end
    n_checks++; if (dout !== 84'h4000) begin n_errors++; $display("FAIL seed1_advance got=%h exp=%h", dout, 84'h4000); end
    // Reset while a word is still pending downstream.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || locked !== 1'b0 || dout !== 84'h0) begin n_errors++; $display("FAIL midop_reset valid=%b locked=%b dout=%h exp 0 0 0", out_valid, locked, dout); end
  endtask

  task automatic test_zero_seed();
    do_reset();
    out_ready = 1'b1;
    send_word(MARK);
    for (int k = 0; k < 6; k++) send_word(14'h0000);
    for (int i = 0; i < FRAME; i++) begin
      send_word(14'(i));
      n_checks++; if (out_valid !== 1'b1 || out_data !== 14'(i)) begin n_errors++; $display("FAIL zero_pass word %0d valid=%b data=%h exp 1 %h", i, out_valid, out_data, 14'(i)); end
    end
    out_ready = 1'b0;
    #1;
    // With the pending word stalled, only CHECK still offers in_ready.
    n_checks++; if (locked !== 1'b1 || in_ready !== 1'b1 || dout !== 84'h0) begin n_errors++; $display("FAIL zero_check_entry locked=%b in_ready=%b dout=%h exp 1 1 0", locked, in_ready, dout); end
    send_word(MARK);
    n_checks++; if (locked !== 1'b0 || out_valid !== 1'b1 || out_data !== 14'd255) begin n_errors++; $display("FAIL zero_pending locked=%b valid=%b data=%h exp 0 1 00ff", locked, out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL zero_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_loopback();
    logic [83:0] ks_end;
    do_reset();
    run_frame(84'hA5A5A5A5A5A5A5A5A5A5A, 1'b1, ks_end);
    // Next marker straight out of CHECK reseeds with a fresh random seed.
    run_frame(84'({$urandom(), $urandom(), $urandom()}), 1'b1, ks_end);
    m_held = ks_end;
  endtask

  task automatic test_sync_loss();
    out_ready = 1'b1;
    send_word(14'h1234);
    n_checks++; if (sync_lost !== 1'b1) begin n_errors++; $display("FAIL sync_lost_pulse got=%b exp=1", sync_lost); end
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL sync_lost_locked got=%b exp=0", locked); end
    tick();
    n_checks++; if (sync_lost !== 1'b0) begin n_errors++; $display("FAIL sync_lost_single got=%b exp=0", sync_lost); end
    send_word(14'h0001);
    n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL idle_drop locked=%b exp=0", locked); end
    // A bus write only lands in IDLE; upper bits show the LFSR was held.
    write_reg(12'h0ac, 32'hDEADBEEF);
    n_checks++; if (dout !== {m_held[83:32], 32'hDEADBEEF}) begin n_errors++; $display("FAIL idle_held_lfsr got=%h exp=%h", dout, {m_held[83:32], 32'hDEADBEEF}); end
  endtask

  task automatic test_backpressure_regs();
    logic [31:0] lo, mid;
    logic [19:0] hi;
    logic [83:0] seed, ks1, ks2;
    logic [13:0] p0, p1;
    do_reset();
    lo = $urandom() | 32'h1; mid = $urandom() | 32'h1; hi = 20'($urandom()) | 20'h1;
    seed = {hi, mid, lo};
    // Register write and marker in the same IDLE cycle: write wins.
    write = 1'b1; addr = 12'h0ac; lfsrdin = lo; in_valid = 1'b1; in_data = MARK;
    tick();
    write = 1'b0; in_valid = 1'b0;
    write_reg(12'h0ad, mid);
    write_reg(12'h0ae, {12'hABC, hi});
    n_checks++; if (locked !== 1'b0 || dout !== seed) begin n_errors++; $display("FAIL reg_seed locked=%b dout=%h exp 0 %h", locked, dout, seed); end
    write_reg(12'h0af, 32'h1);
    n_checks++; if (locked !== 1'b1 || dout !== seed) begin n_errors++; $display("FAIL reg_start locked=%b dout=%h exp 1 %h", locked, dout, seed); end
    p0 = 14'($urandom()); p1 = 14'($urandom());
    ks1 = m_adv(seed); ks2 = m_adv(ks1);
    out_ready = 1'b0;
    send_word(p0 ^ m_ks(seed));
    n_checks++; if (out_valid !== 1'b1 || out_data !== p0 || dout !== ks1) begin n_errors++; $display("FAIL bp_first valid=%b data=%h dout=%h exp 1 %h %h", out_valid, out_data, dout, p0, ks1); end
    in_valid = 1'b1; in_data = p1 ^ m_ks(ks1);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    for (int c = 0; c < 4; c++) begin
      write = (c == 1); addr = 12'h0ac; lfsrdin = 32'h0;
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== p0 || dout !== ks1) begin n_errors++; $display("FAIL bp_hold cycle %0d valid=%b data=%h dout=%h exp 1 %h %h", c, out_valid, out_data, dout, p0, ks1); end
    end
    write = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== p1 || dout !== ks2) begin n_errors++; $display("FAIL bp_accept_drain valid=%b data=%h dout=%h exp 1 %h %h", out_valid, out_data, dout, p1, ks2); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_final_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_zero_seed();
    test_loopback();
    test_sync_loss();
    test_backpressure_regs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
